// File: rtl/pin_probe_pkg.sv
// ---------------------------------------------------------------------------
// pin_probe_pkg : shared encodings, ASCII constants and width helper.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pin_probe_pkg;

  typedef enum logic [0:0] {
    S_SCAN  = 1'b0,
    S_LATCH = 1'b1
  } scan_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  // Index 0 holds '0' because the leftmost character lands in the top byte.
  localparam logic [15:0][7:0] HEX_TABLE = "FEDCBA9876543210";

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return HEX_TABLE[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pin_activity_scanner_if.sv
// ---------------------------------------------------------------------------
// pin_activity_scanner_if : per-pin readout bus (index in, count/flag/level out).
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pin_activity_scanner_if
  import pin_probe_pkg::*;
#(
  parameter int NR_PINS = 128,
  parameter int CNT_W   = 8
);
  // One spare code above the last pin so out-of-range reads can be issued.
  localparam int IDX_W = clog2(NR_PINS + 1);

  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_act;
  logic             rd_level;

  modport master (output rd_idx, input rd_cnt, rd_act, rd_level);
  modport slave  (input rd_idx, output rd_cnt, rd_act, rd_level);

endinterface

`default_nettype wire

// File: rtl/act_uart_tx.sv
// ---------------------------------------------------------------------------
// act_uart_tx : 8N1 serialiser, LSB first, byte accepted on valid & ready.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module act_uart_tx
  import pin_probe_pkg::*;
#(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);
  localparam int BW = clog2(BAUD_DIV);

  tx_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  assign ready = (state == TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else if (state == TX_IDLE) begin
      txd <= 1'b1;
      if (valid) begin
        shreg    <= data;
        txd      <= 1'b0;
        baud_cnt <= '0;
        state    <= TX_START;
      end
    end else if (baud_cnt != BW'(BAUD_DIV - 1)) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      case (state)
        TX_START: begin
          txd     <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          state   <= TX_DATA;
        end
        TX_DATA: begin
          if (bit_cnt == 3'd7) begin
            txd   <= 1'b1;
            state <= TX_STOP;
          end else begin
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pin_activity_scanner.sv
// ---------------------------------------------------------------------------
// pin_activity_scanner : per-pin toggle counters, sticky flags, active-pin scan,
//                        LED heartbeat. Optional UART record with ACT_UART_EN.
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pin_activity_scanner
  import pin_probe_pkg::*;
#(
  parameter int NR_PINS     = 128,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int HB_W        = 25,
  parameter int BAUD_DIV    = 217,
  parameter int DUMP_SCANS  = 1024
) (
  input  logic                         clk25,
  input  logic                         rst,
  input  logic [NR_PINS-1:0]           pins,
  input  logic                         clr_all,
  pin_activity_scanner_if.slave        rd,
  output logic [clog2(NR_PINS+1)-1:0]  act_total,
  output logic                         pin_parity,
  output logic [3:0]                   leds,
  output logic                         uart_txd
);
  localparam int SEL_W = (NR_PINS > 1) ? clog2(NR_PINS) : 1;
  localparam int TOT_W = clog2(NR_PINS + 1);
  localparam int IDX_W = clog2(NR_PINS + 1);

  if (NR_PINS < 1 || SYNC_STAGES < 2 || HB_W < 3 || BAUD_DIV < 2 || DUMP_SCANS < 1)
  begin : g_param_check
    $error("pin_activity_scanner: illegal parameter set");
  end

  logic [NR_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NR_PINS-1:0] synced, prev_q, edges, act;
  logic [SYNC_STAGES:0] prime_sr;
  logic               primed;
  logic [CNT_W-1:0]   cnt [NR_PINS];
  logic [HB_W-1:0]    hb;
  logic               any_act;
  logic [SEL_W-1:0]   rd_sel, scan_idx;
  logic [TOT_W-1:0]   acc;
  scan_state_t        scan_state;
  logic               scan_done;

  assign synced = sync_q[SYNC_STAGES-1];
  // Unprimed until the reset zeros have flushed out of the synchroniser.
  assign primed = prime_sr[SYNC_STAGES];
  assign edges  = primed ? (synced ^ prev_q) : '0;
  assign rd_sel = rd.rd_idx[SEL_W-1:0];
  assign leds   = {any_act, hb[HB_W-1 -: 3]};
  assign scan_done = (scan_state == S_LATCH) && !clr_all;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q     <= '0;
      prime_sr   <= '0;
      hb         <= '0;
      any_act    <= 1'b0;
      pin_parity <= 1'b0;
    end else begin
      sync_q[0] <= pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q     <= synced;
      prime_sr   <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
      hb         <= hb + 1'b1;
      any_act    <= |act;
      pin_parity <= ^synced;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_PINS; i++) cnt[i] <= '0;
      act <= '0;
    end else begin
      for (int i = 0; i < NR_PINS; i++) begin
        if (edges[i]) begin
          act[i] <= 1'b1;
          if (clr_all)
            cnt[i] <= CNT_W'(1);
          else if (cnt[i] != '1)
            cnt[i] <= cnt[i] + 1'b1;
        end else if (clr_all) begin
          cnt[i] <= '0;
          act[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rd.rd_cnt   <= '0;
      rd.rd_act   <= 1'b0;
      rd.rd_level <= 1'b0;
    end else if (rd.rd_idx <= IDX_W'(NR_PINS - 1)) begin
      rd.rd_cnt   <= cnt[rd_sel];
      rd.rd_act   <= act[rd_sel];
      rd.rd_level <= synced[rd_sel];
    end else begin
      rd.rd_cnt   <= '0;
      rd.rd_act   <= 1'b0;
      rd.rd_level <= 1'b0;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      scan_state <= S_SCAN;
      scan_idx   <= '0;
      acc        <= '0;
      act_total  <= '0;
    end else if (clr_all) begin
      scan_state <= S_SCAN;
      scan_idx   <= '0;
      acc        <= '0;
    end else begin
      case (scan_state)
        S_SCAN: begin
          acc <= acc + TOT_W'(act[scan_idx]);
          if (scan_idx == SEL_W'(NR_PINS - 1))
            scan_state <= S_LATCH;
          else
            scan_idx <= scan_idx + 1'b1;
        end
        default: begin
          act_total  <= acc;
          acc        <= '0;
          scan_idx   <= '0;
          scan_state <= S_SCAN;
        end
      endcase
    end
  end

`ifdef ACT_UART_EN
  localparam int SC_W = clog2(DUMP_SCANS + 1);

  logic [SC_W-1:0] scan_cnt;
  logic            dump_due, rec_active, tx_ready;
  logic [2:0]      byte_sel;
  logic [15:0]     snap;
  logic [7:0]      tx_data;

  always_comb begin
    tx_data = ASCII_LF;
    case (byte_sel)
      3'd0:    tx_data = hex_char(snap[15:12]);
      3'd1:    tx_data = hex_char(snap[11:8]);
      3'd2:    tx_data = hex_char(snap[7:4]);
      3'd3:    tx_data = hex_char(snap[3:0]);
      3'd4:    tx_data = ASCII_CR;
      default: tx_data = ASCII_LF;
    endcase
  end

  // The due pulse lags the latch by one cycle so the snapshot sees the fresh total.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      scan_cnt   <= '0;
      dump_due   <= 1'b0;
      rec_active <= 1'b0;
      byte_sel   <= '0;
      snap       <= '0;
    end else begin
      dump_due <= 1'b0;
      if (scan_done) begin
        if (scan_cnt == SC_W'(DUMP_SCANS - 1)) begin
          scan_cnt <= '0;
          dump_due <= 1'b1;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
      if (rec_active) begin
        if (tx_ready) begin
          if (byte_sel == 3'd5) rec_active <= 1'b0;
          else                  byte_sel   <= byte_sel + 1'b1;
        end
      end else if (dump_due && tx_ready) begin
        rec_active <= 1'b1;
        byte_sel   <= '0;
        snap       <= 16'(act_total);
      end
    end
  end

  act_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (clk25),
    .rst   (rst),
    .data  (tx_data),
    .valid (rec_active),
    .ready (tx_ready),
    .txd   (uart_txd)
  );
`else
  assign uart_txd = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pin_activity_scanner.sv
// ---------------------------------------------------------------------------
// tb_pin_activity_scanner : directed vectors for pin_activity_scanner (8 pins).
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pin_activity_scanner;
  localparam int NR = 8;
  localparam int CW = 4;
  localparam int IW = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_all;
  logic [NR-1:0] pins;
  logic [TW-1:0] act_total;
  logic          pin_parity;
  logic [3:0]    leds;
  logic          uart_txd;

  int n_vec  = 0;
  int n_miss = 0;

  pin_activity_scanner_if #(.NR_PINS(NR), .CNT_W(CW)) rif ();

  pin_activity_scanner #(
    .NR_PINS(NR), .SYNC_STAGES(2), .CNT_W(CW), .HB_W(6), .BAUD_DIV(4), .DUMP_SCANS(2)
  ) dut (
    .clk25      (clk),
    .rst        (rst),
    .pins       (pins),
    .clr_all    (clr_all),
    .rd         (rif),
    .act_total  (act_total),
    .pin_parity (pin_parity),
    .leds       (leds),
    .uart_txd   (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_pin(input int idx);
    rif.rd_idx = IW'(idx);
    @(negedge clk);
  endtask

  task automatic toggle(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      pins[p] = ~pins[p];
      repeat (3) @(negedge clk);
    end
  endtask

`ifdef ACT_UART_EN
  task automatic get_byte(output logic [7:0] b, output bit ok);
    int t;
    ok = 1'b0;
    b  = '0;
    t  = 0;
    while (uart_txd !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (uart_txd !== 1'b0) return;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = uart_txd;
    end
    repeat (4) @(negedge clk);
    ok = (uart_txd === 1'b1);
  endtask
`else
  bit txd_low = 1'b0;
  always @(negedge clk) if (rst === 1'b0 && uart_txd !== 1'b1) txd_low <= 1'b1;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pins       = 8'hFF;
    clr_all    = 1'b0;
    rif.rd_idx = '0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_act_total", act_total, 0);
    check("rst_leds", leds, 0);
    check("rst_parity", pin_parity, 0);
    check("rst_txd", uart_txd, 1);
    check("rst_rd_cnt", rif.rd_cnt, 0);

    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("heartbeat_leds", leds[2:0], 3'd1);

    repeat (24) @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      read_pin(i);
      check($sformatf("init_cnt%0d", i), rif.rd_cnt, 0);
      check($sformatf("init_act%0d", i), rif.rd_act, 0);
      check($sformatf("init_level%0d", i), rif.rd_level, 1);
    end
    check("init_act_total", act_total, 0);
    check("init_led3", leds[3], 0);
    check("init_parity", pin_parity, 0);

    toggle(5, 3);
    repeat (4) @(negedge clk);
    read_pin(5);
    check("p5_cnt", rif.rd_cnt, 3);
    check("p5_act", rif.rd_act, 1);
    check("p5_level", rif.rd_level, 0);
    read_pin(4);
    check("p4_cnt", rif.rd_cnt, 0);
    check("parity_7ones", pin_parity, 1);
    repeat (24) @(negedge clk);
    check("p5_act_total", act_total, 1);
    check("p5_led3", leds[3], 1);

    toggle(0, 20);
    repeat (4) @(negedge clk);
    read_pin(0);
    check("p0_sat_cnt", rif.rd_cnt, 15);
    check("p0_act", rif.rd_act, 1);
    repeat (24) @(negedge clk);
    check("two_act_total", act_total, 2);

    toggle(2, 2);
    repeat (4) @(negedge clk);
    read_pin(2);
    check("p2_pre_cnt", rif.rd_cnt, 2);
    pins[2] = ~pins[2];
    repeat (2) @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    repeat (2) @(negedge clk);
    read_pin(2);
    check("clr_p2_cnt", rif.rd_cnt, 1);
    check("clr_p2_act", rif.rd_act, 1);
    read_pin(0);
    check("clr_p0_cnt", rif.rd_cnt, 0);
    check("clr_p0_act", rif.rd_act, 0);
    read_pin(5);
    check("clr_p5_cnt", rif.rd_cnt, 0);
    repeat (24) @(negedge clk);
    check("clr_act_total", act_total, 1);

    read_pin(1);
    check("p1_level", rif.rd_level, 1);
    read_pin(9);
    check("oor_cnt", rif.rd_cnt, 0);
    check("oor_act", rif.rd_act, 0);
    check("oor_level", rif.rd_level, 0);

    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    toggle(1, 1);
    toggle(3, 1);
    toggle(4, 1);
    repeat (24) @(negedge clk);
    check("uart_act_total", act_total, 3);

`ifdef ACT_UART_EN
    begin
      logic [7:0] exp_rec [6];
      logic [7:0] b;
      bit ok;
      int run, t;
      exp_rec = '{8'h30, 8'h30, 8'h30, 8'h33, 8'h0D, 8'h0A};
      run = 0;
      t   = 0;
      while (run < 9 && t < 4000) begin
        @(negedge clk);
        t++;
        run = (uart_txd === 1'b1) ? run + 1 : 0;
      end
      check("uart_idle_gap", (run >= 9) ? 1 : 0, 1);
      for (int i = 0; i < 6; i++) begin
        get_byte(b, ok);
        check($sformatf("uart_frame%0d", i), ok, 1);
        check($sformatf("uart_byte%0d", i), b, exp_rec[i]);
      end
    end
`else
    repeat (300) @(negedge clk);
    check("txd_stays_high", txd_low, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
